// File: rtl/color_pkg.sv
// Shared colour codes, filter FSM state encoding and the legal-code check
// used by the colour event filter.
package color_pkg;

  localparam logic [2:0] COLOR_NONE  = 3'b000;
  localparam logic [2:0] COLOR_RED   = 3'b001;
  localparam logic [2:0] COLOR_BLUE  = 3'b010;
  localparam logic [2:0] COLOR_GREEN = 3'b100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } filt_state_e;

  function automatic logic is_legal_color(input logic [2:0] code);
    logic legal;
    case (code)
      COLOR_NONE, COLOR_RED, COLOR_BLUE, COLOR_GREEN: legal = 1'b1;
      default:                                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Periodic one-cycle tick: counter runs 0..SAMPLE_DIV-1 and ticks on the last value.
// Shared with the motor PWM stage, so keep the port list minimal.
module sample_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/color_event_filter.sv
// Debounces the sensor colour code over STABLE_N ticks and emits one ready/valid event per change.
// COLOR_EVT_TIMESTAMP_EN adds a per-tick sample counter reported on evt_time.
module color_event_filter
  import color_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned STABLE_N   = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       color_in,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [2:0]       evt_color,
  output logic [2:0]       stable_color,
`ifdef COLOR_EVT_TIMESTAMP_EN
  output logic [CNT_W-1:0] evt_time,
`endif
  output logic             evt_drop
);

  localparam int unsigned SW = (STABLE_N > 1) ? $clog2(STABLE_N + 1) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_N);

  logic          tick, tick_q;
  logic [2:0]    sample_q;
  filt_state_e   state_q, state_d;
  logic [2:0]    cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d, stab_inc;
  logic [2:0]    stable_q, stable_d;
  logic          accept;
  logic [2:0]    acc_color;
  logic          evt_valid_q, evt_valid_d;
  logic [2:0]    evt_color_q, evt_color_d;
  logic          drop_q, drop_d;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // The FSM runs on tick_q, one cycle after the sample is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= 1'b0;
      sample_q <= COLOR_NONE;
    end else begin
      tick_q <= tick;
      if (tick) sample_q <= is_legal_color(color_in) ? color_in : COLOR_NONE;
    end
  end

  assign stab_inc = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    stab_d    = stab_q;
    accept    = 1'b0;
    acc_color = cand_q;
    if (tick_q) begin
      case (state_q)
        ST_IDLE: begin
          if (sample_q == stable_q) begin
            stab_d = '0;
          end else if (STABLE_N == 1) begin
            cand_d    = sample_q;
            stab_d    = STAB_MAX;
            accept    = 1'b1;
            acc_color = sample_q;
          end else begin
            cand_d  = sample_q;
            stab_d  = SW'(1);
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (sample_q == cand_q) begin
            stab_d = stab_inc;
            if (stab_inc == STAB_MAX) begin
              accept  = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (sample_q == stable_q) begin
            stab_d  = '0;
            state_d = ST_IDLE;
          end else begin
            cand_d = sample_q;
            stab_d = SW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // An accept wins over a transfer; it only counts as a drop if the old event was not taken.
  always_comb begin
    stable_d    = stable_q;
    evt_valid_d = evt_valid_q;
    evt_color_d = evt_color_q;
    drop_d      = 1'b0;
    if (accept) begin
      stable_d    = acc_color;
      evt_valid_d = 1'b1;
      evt_color_d = acc_color;
      drop_d      = evt_valid_q & ~evt_ready;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= COLOR_NONE;
      stab_q      <= '0;
      stable_q    <= COLOR_NONE;
      evt_valid_q <= 1'b0;
      evt_color_q <= COLOR_NONE;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      stable_q    <= stable_d;
      evt_valid_q <= evt_valid_d;
      evt_color_q <= evt_color_d;
      drop_q      <= drop_d;
    end
  end

`ifdef COLOR_EVT_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_q, evt_time_q;

  // ts_q already includes the accepting tick when the FSM evaluates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      evt_time_q <= '0;
    end else begin
      if (tick)   ts_q       <= ts_q + 1'b1;
      if (accept) evt_time_q <= ts_q;
    end
  end

  assign evt_time = evt_time_q;
`endif

  assign evt_valid    = evt_valid_q;
  assign evt_color    = evt_color_q;
  assign stable_color = stable_q;
  assign evt_drop     = drop_q;

endmodule
